cordic_magnitude: RTL and testbench
===================================

Name: cordic_magnitude

Overview:
- Fully pipelined CORDIC in vectoring mode.
- Computes the magnitude sqrt(x^2 + y^2) of a signed fixed-point vector (x, y).
- Accepts one sample per clock and returns results in order after a fixed latency.
- Used as a streaming magnitude/norm unit feeding downstream fixed-point datapaths.

Parameters:
- Q_I, 15, integer bits of the signed fixed-point format (excluding sign).
- Q_F, 16, fractional bits.
- ITERATIONS, 16, number of CORDIC micro-rotation stages (1..Q_F+Q_I).
- Derived, not overridable: WIDTH = Q_I + Q_F + 1.

Ports:
- clk_i  input  1  clock; all logic on rising edge.
- rst_i  input  1  synchronous, active-high reset.
- valid_i  input  1  input sample valid.
- x_data_i  input  WIDTH  x operand, two's complement, Q_I.Q_F.
- y_data_i  input  WIDTH  y operand, two's complement, Q_I.Q_F.
- valid_o  output  1  data_o holds a new result this cycle.
- data_o  output  WIDTH  magnitude, Q_I.Q_F, always >= 0.

Behaviour:
- Reset: rst_i high at a rising edge clears every pipeline valid bit and every data register. valid_o=0 and data_o=0 from the next cycle. In-flight samples are discarded, with no partial output after reset is released.
- No backpressure. A sample is captured on every rising edge with valid_i=1, so throughput is 1 result/cycle.
- Latency: exactly ITERATIONS+2 cycles from the capturing edge to valid_o=1 with the corresponding data_o.
- Bubbles in valid_i propagate as bubbles in valid_o. Order is preserved.
- Data registers of a stage load only when that stage's valid bit is set. data_o therefore holds the last result while valid_o=0.
- Internal datapath width is WIDTH+2 (guard bits for the sqrt(2) vector growth and the CORDIC gain of about 1.6468).
- Stage 0 (input register): x0=|x|, y0=|y|, sign-extended to the internal width. Magnitude is invariant under this mapping. The most-negative input is handled by the extra bits.
- Stage i, i=0..ITERATIONS-1 (one register each): d = +1 if y>=0, else -1. Then x' = x + d*(y>>>i) and y' = y - d*(x>>>i). Shifts are arithmetic; no angle accumulator.
- Final stage (gain compensation): m = (x_N * K) >>> Q_F, with K = round(0.6072529350 * 2^Q_F) as an unsigned constant. Default truncates toward zero.
- Saturation: if m > 2^(WIDTH-1)-1, data_o = 2^(WIDTH-1)-1 (0x7FFFFFFF at defaults). data_o is never negative.
- Accuracy at defaults: |data_o - exact| <= 2^-13 * exact + 8 LSB.
- Zero input (0,0) yields exactly 0.
- valid_i asserted during the reset cycle is ignored.

Optional Feature:
- Macro: CORDIC_ROUND_EN.
- Defined: gain stage rounds half-up, m = (x_N*K + 2^(Q_F-1)) >>> Q_F, then saturates. Latency is unchanged.
- Undefined: truncation as described in Behaviour.

Test Plan:
- Reset: hold rst_i for 6 cycles, valid_i=0 -> valid_o=0 and data_o=0 throughout. After release, nothing is emitted until a sample is supplied.
- Single sample (3.0, 4.0) -> exactly ITERATIONS+2 cycles later valid_o=1 for one cycle, with data_o within tolerance of 5.0 (0x00050000). Repeat for (-3.0, -4.0) -> 5.0, and (0, 0) -> 0x00000000.
- Stream 1024 back-to-back samples x=y=k for k=1..1024 -> 1024 consecutive valid_o pulses in order. Each data_o is within tolerance of k*1.41421356; the last is about 1448.1547.
- Gapped stream with valid_i alternating 1/0 on (1,0),(0,2),(-5,12) -> results 1.0, 2.0, 13.0 with the same gaps. data_o holds its value during gaps.
- Saturation: (32767.0, 32767.0) -> data_o=0x7FFFFFFF. Most-negative inputs (0x80000000, 0) -> 0x7FFFFFFF.
- Reset mid-stream: assert rst_i for 1 cycle while 5 samples are in flight -> valid_o=0 for those samples. The next sample after reset returns correctly after ITERATIONS+2 cycles.

Source files
------------

// File: rtl/cordic_magnitude.sv
// cordic_magnitude: fully pipelined vectoring-mode CORDIC returning
// sqrt(x^2 + y^2) for signed Q_I.Q_F inputs, one sample per clock,
// fixed latency of ITERATIONS+2 cycles, results in order.
//
// Pipeline: absolute-value input register, ITERATIONS micro-rotation
// registers, gain-multiply register, shift/saturate output register.
//
// Optional build macro CORDIC_ROUND_EN: the gain stage rounds half-up
// instead of truncating. Latency is identical in both builds.
module cordic_magnitude #(
  parameter int Q_I        = 15,
  parameter int Q_F        = 16,
  parameter int ITERATIONS = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic [Q_I+Q_F:0]       x_data_i,
  input  logic [Q_I+Q_F:0]       y_data_i,
  output logic                   valid_o,
  output logic [Q_I+Q_F:0]       data_o
);

  localparam int WIDTH = Q_I + Q_F + 1;
  // Two guard bits: |(-2^(W-1))| plus sqrt(2) growth plus CORDIC gain ~1.647.
  localparam int IW    = WIDTH + 2;
  // Product width: final x is non-negative (< 2^(IW-1)) and K < 2^Q_F.
  localparam int PW    = IW + Q_F;

  // Inverse CORDIC gain, rounded to Q_F fractional bits.
  localparam logic [Q_F-1:0] K =
    Q_F'($rtoi(0.6072529350 * (2.0 ** Q_F) + 0.5));

  localparam logic [WIDTH-1:0] MAX_MAG = {1'b0, {(WIDTH-1){1'b1}}};

  // x_q[0]/y_q[0] hold |x|,|y|; x_q[i+1]/y_q[i+1] hold the result of rotation i.
  logic signed [IW-1:0] x_q [0:ITERATIONS];
  logic signed [IW-1:0] y_q [0:ITERATIONS];
  logic                 v_q [0:ITERATIONS];

  logic [PW-1:0]        p_q;
  logic                 p_v_q;

  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] y_ext;
  logic signed [IW-1:0] x_abs;
  logic signed [IW-1:0] y_abs;
  logic [PW-1:0]        p_adj;
  logic [PW-1:0]        m_full;
  logic [WIDTH-1:0]     m_sat;

  // Sign-extend and take absolute values; the guard bits make -(-2^(W-1)) exact.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, otherwise a latch is inferred.
    x_ext = {{2{x_data_i[WIDTH-1]}}, x_data_i};
    y_ext = {{2{y_data_i[WIDTH-1]}}, y_data_i};
    x_abs = x_ext[IW-1] ? -x_ext : x_ext;
    y_abs = y_ext[IW-1] ? -y_ext : y_ext;
  end

  // Input register and micro-rotation stages; data moves only with its valid bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: data registers are cleared too, so data_o reads 0 after reset rather than stale pipeline contents.
      for (int i = 0; i <= ITERATIONS; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        v_q[i] <= 1'b0;
      end
    end else begin
      // NOTE: non-blocking assignments so every stage samples the previous stage's pre-edge value.
      v_q[0] <= valid_i;
      if (valid_i) begin
        x_q[0] <= x_abs;
        y_q[0] <= y_abs;
      end
      for (int i = 0; i < ITERATIONS; i++) begin
        v_q[i+1] <= v_q[i];
        if (v_q[i]) begin
          if (!y_q[i][IW-1]) begin
            // d = +1: rotate clockwise toward the x axis.
            x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
            y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
          end else begin
            // d = -1: rotate counter-clockwise toward the x axis.
            x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
            y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
          end
        end
      end
    end
  end

  // Gain compensation multiply; x_N is never negative after the first rotation.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p_q   <= '0;
      p_v_q <= 1'b0;
    end else begin
      p_v_q <= v_q[ITERATIONS];
      if (v_q[ITERATIONS]) begin
        p_q <= PW'($unsigned(x_q[ITERATIONS])) * PW'(K);
      end
    end
  end

  // Drop the Q_F fraction bits of K (truncate or round half-up) and saturate.
  always_comb begin
`ifdef CORDIC_ROUND_EN
    p_adj = p_q + (PW'(1) << (Q_F - 1));
`else
    p_adj = p_q;
`endif
    m_full = p_adj >> Q_F;
    m_sat  = (m_full > PW'(MAX_MAG)) ? MAX_MAG : m_full[WIDTH-1:0];
  end

  // Output register; data_o holds the last result through bubbles.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= p_v_q;
      if (p_v_q) begin
        data_o <= m_sat;
      end
    end
  end

endmodule

// File: tb/tb_cordic_magnitude.sv
// tb_cordic_magnitude: randomized and directed stimulus for cordic_magnitude,
// checked every cycle against a real-arithmetic magnitude model with the
// accuracy bound |err| <= exact/8192 + 8 LSB, plus literal expectations.
module tb_cordic_magnitude;

  localparam int     ITER  = 16;
  localparam int     W     = 32;
  localparam int     LAT   = ITER + 2;
  localparam int     DEPTH = 8192;
  localparam longint MAXV  = 64'h0000_0000_7FFF_FFFF;
  localparam longint ONE   = 64'd65536;

  logic         clk      = 1'b0;
  logic         rst_i    = 1'b1;
  logic         valid_i  = 1'b0;
  logic [W-1:0] x_data_i = '0;
  logic [W-1:0] y_data_i = '0;
  logic         valid_o;
  logic [W-1:0] data_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cordic_magnitude #(
    .Q_I        (15),
    .Q_F        (16),
    .ITERATIONS (ITER)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .valid_i  (valid_i),
    .x_data_i (x_data_i),
    .y_data_i (y_data_i),
    .valid_o  (valid_o),
    .data_o   (data_o)
  );

  task automatic check(input string name, input longint act, input longint lo, input longint hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d..%0d at %0t", name, act, lo, hi, $time);
    end
  endtask

  function automatic real mag(input logic [W-1:0] x, input logic [W-1:0] y);
    real rx;
    real ry;
    rx = $itor($signed(x));
    ry = $itor($signed(y));
    return $sqrt(rx * rx + ry * ry);
  endfunction

  // Model: what was accepted on each edge and the exact magnitude it implies.
  bit  cap_v  [DEPTH];
  real cap_ex [DEPTH];
  int  cyc      = 0;
  int  last_rst = 0;

  always @(posedge clk) begin
    if (cyc + 1 >= DEPTH) begin
      $display("FAIL model_depth: got cycle %0d, want below %0d", cyc + 1, DEPTH);
      $fatal(1);
    end
    cyc           <= cyc + 1;
    cap_v[cyc+1]  <= valid_i && !rst_i;
    cap_ex[cyc+1] <= mag(x_data_i, y_data_i);
    if (rst_i) last_rst <= cyc + 1;
  end

  // Compare every cycle: a sample accepted at edge s appears after edge s+LAT
  // unless a reset edge fell in between; data_o holds the last result.
  real held_ex = 0.0;
  int  vcount  = 0;

  always @(negedge clk) begin
    int  s;
    bit  ev;
    real e;
    real tol;
    if (last_rst > 0) begin
      s  = cyc - LAT;
      ev = 1'b0;
      if (s >= 1) ev = cap_v[s] && (last_rst <= s);
      if (last_rst == cyc) held_ex = 0.0;
      else if (ev)         held_ex = cap_ex[s];
      check("valid_o", longint'(valid_o), longint'(ev), longint'(ev));
      e   = (held_ex > $itor(MAXV)) ? $itor(MAXV) : held_ex;
      tol = (held_ex == 0.0) ? 0.0 : held_ex / 8192.0 + 8.0;
      check("data_o", longint'(data_o), longint'($ceil(e - tol)), longint'($floor(e + tol)));
      if (valid_o) vcount++;
    end
  end

  task automatic drive(input bit v, input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    valid_i  = v;
    x_data_i = x;
    y_data_i = y;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, '0);
  endtask

  // One isolated sample: latency must be exactly LAT, value within [lo, hi].
  task automatic run_one(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                         input longint lo, input longint hi);
    int lat;
    drive(1'b1, x, y);
    drive(1'b0, '0, '0);
    lat = 0;
    while (!valid_o && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, longint'(lat), LAT, LAT);
    check(name, longint'(data_o), lo, hi);
    idle(2);
  endtask

  initial begin
    int            v0;
    int            sh;
    logic signed [W-1:0] rx;
    logic signed [W-1:0] ry;

    // Reset held for 6 edges with valid_i low.
    rst_i = 1'b1;
    repeat (6) @(negedge clk);
    rst_i = 1'b0;
    v0 = vcount;
    idle(12);
    check("idle_after_reset", longint'(vcount - v0), 0, 0);
    check("idle_data_zero", longint'(data_o), 0, 0);

    // Directed single samples.
    run_one("mag_3_4",   32'h0003_0000, 32'h0004_0000, 5 * ONE - 16, 5 * ONE + 16);
    run_one("mag_m3_m4", 32'hFFFD_0000, 32'hFFFC_0000, 5 * ONE - 16, 5 * ONE + 16);
    run_one("mag_zero",  32'h0000_0000, 32'h0000_0000, 0, 0);

    // Back-to-back ramp x = y = k.
    v0 = vcount;
    for (int k = 1; k <= 1024; k++) drive(1'b1, W'(k) << 16, W'(k) << 16);
    idle(LAT + 4);
    check("ramp_count", longint'(vcount - v0), 1024, 1024);
    check("ramp_last_hold", longint'(data_o), 64'd94906266 - 11593, 64'd94906266 + 11593);

    // Gapped stream: bubbles propagate, data_o holds.
    v0 = vcount;
    drive(1'b1, 32'h0001_0000, 32'h0000_0000);
    drive(1'b0, '0, '0);
    drive(1'b1, 32'h0000_0000, 32'h0002_0000);
    drive(1'b0, '0, '0);
    drive(1'b1, 32'hFFFB_0000, 32'h000C_0000);
    drive(1'b0, '0, '0);
    idle(LAT + 4);
    check("gap_count", longint'(vcount - v0), 3, 3);
    check("gap_last_hold", longint'(data_o), 13 * ONE - 112, 13 * ONE + 112);

    // Saturation.
    run_one("sat_max",   32'h7FFF_0000, 32'h7FFF_0000, MAXV, MAXV);
    run_one("sat_mneg",  32'h8000_0000, 32'h0000_0000, MAXV, MAXV);

    // Reset with 5 samples in flight; valid_i high during the reset edge is ignored.
    v0 = vcount;
    for (int k = 0; k < 5; k++) drive(1'b1, $urandom, $urandom);
    @(negedge clk);
    rst_i    = 1'b1;
    valid_i  = 1'b1;
    x_data_i = 32'h0007_0000;
    y_data_i = 32'h0001_0000;
    @(negedge clk);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    idle(LAT + 4);
    check("flush_count", longint'(vcount - v0), 0, 0);
    check("flush_data_zero", longint'(data_o), 0, 0);
    run_one("after_reset", 32'h0006_0000, 32'h0008_0000, 10 * ONE - 88, 10 * ONE + 88);

    // Randomized traffic with bubbles and occasional resets.
    for (int n = 0; n < 800; n++) begin
      sh = $urandom_range(0, 14);
      rx = $signed($urandom) >>> sh;
      ry = $signed($urandom) >>> $urandom_range(0, 31);
      if (rx > -65536 && rx < 65536) rx = rx + 32'sd131072;
      @(negedge clk);
      rst_i    = ($urandom_range(0, 149) == 0);
      valid_i  = ($urandom_range(0, 3) != 0);
      x_data_i = rx;
      y_data_i = ry;
    end
    @(negedge clk);
    rst_i   = 1'b0;
    valid_i = 1'b0;
    idle(LAT + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
